// File: rtl/bist_sig_analyzer.sv
// BIST signature analyzer: compacts a 3-bit pattern stream into a MISR (x^3+x+1) over PATTERNS
// valid samples, then freezes the signature. Define BIST_GOLDEN_CMP_EN to build the golden compare.
module bist_sig_analyzer #(
   parameter int unsigned      WIDTH    = 3,
   parameter int unsigned      PATTERNS = 7,
   parameter logic [WIDTH-1:0] SEED     = 3'b000,
   parameter logic [WIDTH-1:0] GOLDEN   = 3'b101
) (
   input  logic             clk,
   input  logic             set,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic [WIDTH-1:0] sig,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

   localparam logic [7:0] LastCount = 8'(PATTERNS);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sig_q, sig_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] misr_next;

   // Internal-XOR MISR: shift up with x^3 folded back into taps x^1 and x^0.
   always_comb begin
      misr_next    = sig_q;
      misr_next[0] = sig_q[2] ^ din[0];
      misr_next[1] = sig_q[0] ^ sig_q[2] ^ din[1];
      misr_next[2] = sig_q[1] ^ din[2];
   end

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle, StDone: begin
            // A start that collides with din_valid is taken as a start only.
            if (start) begin
               state_d = StRun;
               sig_d   = SEED;
               cnt_d   = '0;
            end
         end
         StRun: begin
            if (din_valid) begin
               sig_d = misr_next;
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == LastCount) begin
                  state_d = StDone;
               end
            end
         end
         default: begin
            state_d = StIdle;
            sig_d   = SEED;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (set) begin
         state_q <= StIdle;
         sig_q   <= SEED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sig  = sig_q;
   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);

`ifdef BIST_GOLDEN_CMP_EN
   assign pass = (state_q == StDone) && (sig_q == GOLDEN);
`else
   assign pass = 1'b0;
`endif

   a_busy_done_excl : assert property (@(posedge clk) disable iff (set) !(busy && done));
   a_cnt_bounded : assert property (@(posedge clk) disable iff (set) cnt_q <= LastCount);

endmodule
